// File: rtl/ame_pkg.sv
// Shared definitions for the Cramer-rule issue block: FSM state encoding
// and the index maps for the input system and the compute-unit operand lanes.
package ame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISS_DET = 3'd1,
    ST_ISS_DX  = 3'd2,
    ST_ISS_DY  = 3'd3,
    ST_WAIT    = 3'd4,
    ST_OUT     = 3'd5
  } state_t;

  // Positions of the coefficients inside the input system word.
  localparam int OP_A = 0;
  localparam int OP_B = 1;
  localparam int OP_C = 2;
  localparam int OP_D = 3;
  localparam int OP_E = 4;
  localparam int OP_F = 5;

  // Operand lanes toward the compute unit, which returns M*D - L*C.
  localparam int SLOT_M = 3;
  localparam int SLOT_D = 2;
  localparam int SLOT_L = 1;
  localparam int SLOT_C = 0;

endpackage

// File: rtl/ame_cramer_issue.sv
// Issues the three 2x2 cross products of Cramer's rule (det, dx, dy) to an
// external multiply-subtract unit, collects the in-order results and hands
// them downstream as one triple.
// Optional feature: define AME_CRAMER_SINGULAR_EN to add out_sing_o and
// zero dx/dy whenever the determinant is zero.
module ame_cramer_issue
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [5:0][COMP_DATA_BITS-1:0] in_data_i,
  output logic                           comp_init_o,
  output logic [3:0][COMP_DATA_BITS-1:0] comp_data_o,
  input  logic                           comp_done_i,
  input  logic [COMP_DATA_BITS-1:0]      comp_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
`ifdef AME_CRAMER_SINGULAR_EN
  output logic                           out_sing_o,
`endif
  output logic [COMP_DATA_BITS-1:0]      out_det_o,
  output logic [COMP_DATA_BITS-1:0]      out_dx_o,
  output logic [COMP_DATA_BITS-1:0]      out_dy_o
);

  state_t                           state_q;
  state_t                           state_d;
  logic [5:0][COMP_DATA_BITS-1:0]   sys_q;
  logic [1:0]                       done_cnt_q;
  logic [COMP_DATA_BITS-1:0]        det_q;
  logic [COMP_DATA_BITS-1:0]        dx_q;
  logic [COMP_DATA_BITS-1:0]        dy_q;
  logic                             ready_en_q;
  logic                             accept;
  logic                             done_take;

  assign accept = in_valid_i && in_ready_o;

  // Results are only meaningful once the matching request has gone out, so
  // strobes in IDLE, ISS_DET and OUT (e.g. stragglers after a reset) are dropped.
  assign done_take = comp_done_i &&
                     ((state_q == ST_ISS_DX) || (state_q == ST_ISS_DY) ||
                      (state_q == ST_WAIT));

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: three back-to-back issues, then wait for three results.
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves the
    // signal unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_ISS_DET;
      ST_ISS_DET: state_d = ST_ISS_DX;
      ST_ISS_DX:  state_d = ST_ISS_DY;
      ST_ISS_DY:  state_d = ST_WAIT;
      ST_WAIT:    if (done_take && (done_cnt_q == 2'd2)) state_d = ST_OUT;
      ST_OUT:     if (out_ready_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Moore outputs: handshakes and the operand lanes for each issue slot.
  always_comb begin
    in_ready_o  = 1'b0;
    comp_init_o = 1'b0;
    comp_data_o = '0;
    out_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: in_ready_o = ready_en_q;
      ST_ISS_DET: begin
        comp_init_o         = 1'b1;
        comp_data_o[SLOT_M] = sys_q[OP_A];
        comp_data_o[SLOT_D] = sys_q[OP_D];
        comp_data_o[SLOT_L] = sys_q[OP_B];
        comp_data_o[SLOT_C] = sys_q[OP_C];
      end
      ST_ISS_DX: begin
        comp_init_o         = 1'b1;
        comp_data_o[SLOT_M] = sys_q[OP_E];
        comp_data_o[SLOT_D] = sys_q[OP_D];
        comp_data_o[SLOT_L] = sys_q[OP_B];
        comp_data_o[SLOT_C] = sys_q[OP_F];
      end
      ST_ISS_DY: begin
        comp_init_o         = 1'b1;
        comp_data_o[SLOT_M] = sys_q[OP_A];
        comp_data_o[SLOT_D] = sys_q[OP_F];
        comp_data_o[SLOT_L] = sys_q[OP_E];
        comp_data_o[SLOT_C] = sys_q[OP_C];
      end
      ST_OUT:  out_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Captured system coefficients.
  always_ff @(posedge clk_i) begin
    // NOTE: no reset on this data register; it is only driven onto comp_data_o
    // in the issue states, which are reachable only after it has been loaded.
    if (accept) sys_q <= in_data_i;
  end

  // Result collection and the post-reset ready qualifier.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_en_q <= 1'b0;
      done_cnt_q <= 2'd0;
      det_q      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        done_cnt_q <= 2'd0;
      end else if (done_take) begin
        done_cnt_q <= done_cnt_q + 2'd1;
        case (done_cnt_q)
          2'd0:    det_q <= comp_data_i;
          2'd1:    dx_q  <= comp_data_i;
          2'd2:    dy_q  <= comp_data_i;
          default: ;
        endcase
      end
    end
  end

  assign out_det_o = det_q;

`ifdef AME_CRAMER_SINGULAR_EN
  logic singular;
  assign singular   = (det_q == '0);
  assign out_sing_o = (state_q == ST_OUT) && singular;
  assign out_dx_o   = singular ? '0 : dx_q;
  assign out_dy_o   = singular ? '0 : dy_q;
`else
  assign out_dx_o   = dx_q;
  assign out_dy_o   = dy_q;
`endif

endmodule

// File: tb/tb_ame_cramer_issue.sv
// Bench for ame_cramer_issue: a behavioural multiply-subtract unit with
// configurable latency, a transaction-level model of the block, directed
// scenarios with literal results and a randomized stream.
module tb_ame_cramer_issue;

  localparam int W = 64;
  typedef logic [W-1:0] word_t;
  typedef struct {
    int    due;
    word_t val;
  } resp_t;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [5:0][W-1:0] in_data_i = '0;
  logic              comp_init_o;
  logic [3:0][W-1:0] comp_data_o;
  logic              comp_done_i = 1'b0;
  word_t             comp_data_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
`ifdef AME_CRAMER_SINGULAR_EN
  logic              out_sing_o;
`endif
  word_t             out_det_o;
  word_t             out_dx_o;
  word_t             out_dy_o;

  ame_cramer_issue #(.COMP_DATA_BITS(W)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .comp_init_o (comp_init_o),
    .comp_data_o (comp_data_o),
    .comp_done_i (comp_done_i),
    .comp_data_i (comp_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
`ifdef AME_CRAMER_SINGULAR_EN
    .out_sing_o  (out_sing_o),
`endif
    .out_det_o   (out_det_o),
    .out_dx_o    (out_dx_o),
    .out_dy_o    (out_dy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Compute-unit model: in-order responses, latency >= 1.
  resp_t uq[$];
  int    unit_lat  = 1;
  bit    unit_rand = 1'b0;
  int    last_due  = 0;

  // Block model state (transaction level).
  bit    m_ready_en = 1'b0;
  bit    m_busy     = 1'b0;
  bit    m_out      = 1'b0;
  int    m_k        = 0;
  int    m_dones    = 0;
  word_t m_ops[3][4];
  word_t m_det, m_dx, m_dy;

  // Per-cycle comparison, unit response drive and model update, mid-cycle.
  always @(negedge clk_i) begin
    bit    exp_ready, exp_init;
    word_t a, b, c, d, e, f, exp_dx, exp_dy;
    int    lat, due;
    if (!rst_n_i) begin
      check("rst_in_ready", word_t'(in_ready_o), 0);
      check("rst_comp_init", word_t'(comp_init_o), 0);
      check("rst_out_valid", word_t'(out_valid_o), 0);
      check("rst_comp_data", word_t'(|comp_data_o), 0);
      check("rst_det", out_det_o, 0);
      check("rst_dx", out_dx_o, 0);
      check("rst_dy", out_dy_o, 0);
      m_busy = 1'b0; m_out = 1'b0; m_ready_en = 1'b0;
    end else begin
      exp_ready = m_ready_en && !m_busy;
      exp_init  = m_busy && (m_k <= 2);
      check("in_ready", word_t'(in_ready_o), word_t'(exp_ready));
      check("comp_init", word_t'(comp_init_o), word_t'(exp_init));
      for (int s = 0; s < 4; s++)
        check($sformatf("comp_data[%0d]", s), comp_data_o[s],
              exp_init ? m_ops[m_k][s] : '0);
      check("out_valid", word_t'(out_valid_o), word_t'(m_out));
      if (m_out) begin
        exp_dx = m_dx; exp_dy = m_dy;
`ifdef AME_CRAMER_SINGULAR_EN
        check("out_sing", word_t'(out_sing_o), word_t'(m_det == 0));
        if (m_det == 0) begin exp_dx = 0; exp_dy = 0; end
`endif
        check("out_det", out_det_o, m_det);
        check("out_dx", out_dx_o, exp_dx);
        check("out_dy", out_dy_o, exp_dy);
      end
    end

    // Unit: deliver a due response, then take any new request.
    comp_done_i = 1'b0;
    comp_data_i = '0;
    if (uq.size() > 0 && uq[0].due <= cyc) begin
      comp_done_i = 1'b1;
      comp_data_i = uq[0].val;
      void'(uq.pop_front());
    end
    if (comp_init_o) begin
      lat = unit_rand ? int'($urandom_range(1, 5)) : unit_lat;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      uq.push_back('{due, comp_data_o[3] * comp_data_o[2] - comp_data_o[1] * comp_data_o[0]});
    end

    // Model: what the upcoming clock edge does.
    if (rst_n_i) begin
      if (m_busy) begin
        if (m_out) begin
          if (out_ready_i) begin m_busy = 1'b0; m_out = 1'b0; end
        end else begin
          if (comp_done_i && m_k >= 1) begin
            m_dones++;
            if (m_dones == 3) m_out = 1'b1;
          end
          m_k++;
        end
      end else if (in_valid_i && m_ready_en) begin
        a = in_data_i[0]; b = in_data_i[1]; c = in_data_i[2];
        d = in_data_i[3]; e = in_data_i[4]; f = in_data_i[5];
        m_ops[0][3] = a; m_ops[0][2] = d; m_ops[0][1] = b; m_ops[0][0] = c;
        m_ops[1][3] = e; m_ops[1][2] = d; m_ops[1][1] = b; m_ops[1][0] = f;
        m_ops[2][3] = a; m_ops[2][2] = f; m_ops[2][1] = e; m_ops[2][0] = c;
        m_det = a * d - b * c;
        m_dx  = e * d - b * f;
        m_dy  = a * f - e * c;
        m_busy = 1'b1; m_k = 0; m_dones = 0;
      end
      m_ready_en = 1'b1;
    end
  end

  // Present one system and hold it until accepted (entered at posedge+1).
  task automatic send(input word_t a, b, c, d, e, f);
    bit acc;
    int tries;
    in_data_i[0] = a; in_data_i[1] = b; in_data_i[2] = c;
    in_data_i[3] = d; in_data_i[4] = e; in_data_i[5] = f;
    in_valid_i = 1'b1;
    tries = 0;
    do begin
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i);
      #1;
      tries++;
    end while (!acc && tries < 200);
    in_valid_i = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  // Wait for out_valid_o; returns cycles waited after the accept edge.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid_o && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (!out_valid_o) check("out_valid_timeout", 0, 1);
  endtask

  task automatic handshake();
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
  endtask

  function automatic word_t rnd();
    if ($urandom_range(0, 3) == 0) return word_t'($urandom_range(0, 9));
    return {$urandom, $urandom};
  endfunction

  initial begin
    int n, tries;
    word_t a, b, c, d, e, f;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Worked example, 1-cycle unit.
    unit_rand = 1'b0; unit_lat = 1;
    send(3, 2, 1, 4, 5, 6);
    wait_out(n);
    check("lat1_valid_cycle", word_t'(n), 4);
    check("lat1_det", out_det_o, 10);
    check("lat1_dx", out_dx_o, 8);
    check("lat1_dy", out_dy_o, 13);
    handshake();
    check("ready_after_hs", word_t'(in_ready_o), 1);

    // 3-cycle unit, then downstream stalls for 10 cycles.
    unit_lat = 3;
    send(3, 2, 1, 4, 5, 6);
    wait_out(n);
    for (int i = 0; i < 10; i++) begin
      check("stall_det", out_det_o, 10);
      check("stall_dx", out_dx_o, 8);
      check("stall_dy", out_dy_o, 13);
      check("stall_ready", word_t'(in_ready_o), 0);
      @(posedge clk_i);
      #1;
    end
    handshake();
    check("ready_after_stall", word_t'(in_ready_o), 1);

    // Reset in WAIT after one response; the rest arrive while idle.
    unit_lat = 4;
    send(rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
    tries = 0;
    do begin @(negedge clk_i); tries++; end while (!comp_done_i && tries < 50);
    check("reset_test_done_seen", word_t'(comp_done_i), 1);
    @(posedge clk_i);
    #1 rst_n_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("rstw_valid", word_t'(out_valid_o), 0);
    check("rstw_det", out_det_o, 0);
    rst_n_i = 1'b1;
    tries = 0;
    while (uq.size() > 0 && tries < 50) begin @(posedge clk_i); #1; tries++; end
    repeat (2) @(posedge clk_i);
    #1;
    unit_lat = 2;
    send(3, 2, 1, 4, 5, 6);
    wait_out(n);
    check("post_rst_det", out_det_o, 10);
    check("post_rst_dx", out_dx_o, 8);
    check("post_rst_dy", out_dy_o, 13);
    handshake();

`ifdef AME_CRAMER_SINGULAR_EN
    unit_lat = 1;
    send(2, 4, 1, 2, 1, 1);
    wait_out(n);
    check("sing_flag", word_t'(out_sing_o), 1);
    check("sing_det", out_det_o, 0);
    check("sing_dx", out_dx_o, 0);
    check("sing_dy", out_dy_o, 0);
    handshake();
`endif

    // Randomized stream: random latencies, gaps, back-pressure, stray valids.
    unit_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      a = rnd(); b = rnd(); c = rnd(); d = rnd(); e = rnd(); f = rnd();
      send(a, b, c, d, e, f);
      tries = 0;
      do begin
        out_ready_i = 1'($urandom_range(0, 1));
        in_valid_i  = 1'($urandom_range(0, 1));
        in_data_i[0] = rnd();
        @(negedge clk_i);
        n = int'(out_valid_o && out_ready_i);
        @(posedge clk_i);
        #1;
        tries++;
      end while (n == 0 && tries < 300);
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      if (n == 0) check("rand_hs_timeout", 0, 1);
    end

    repeat (4) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
